// File: rtl/axi_wr_master_pkg.sv
// axi_wr_master_pkg: shared FSM states, AXI encodings and helpers for the stream write master.
package axi_wr_master_pkg;

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} wm_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi4_stream_wr_master.sv
// axi4_stream_wr_master: splits one {addr, beats} command plus a data stream into
// single-outstanding AXI4 INCR write bursts of at most MAX_BURST beats.
module axi4_stream_wr_master
    import axi_wr_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 64,
    parameter int ADDR_STEP  = 8,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_beats_i,
    input  logic [ID_WIDTH-1:0]     cmd_id_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ID_WIDTH-1:0]     axi_awid_o,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
    output logic [7:0]              axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [ID_WIDTH-1:0]     axi_bid_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o
);

    wm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  burst;
    logic                  unused_bid;

    assign unused_bid = ^axi_bid_i;
    assign burst = (rem_q > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : rem_q;

    assign cmd_ready_o   = (state_q == IDLE) && !rst_i;
    assign axi_awvalid_o = (state_q == AW);
    assign axi_awid_o    = id_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = 8'(burst - LEN_WIDTH'(1));
    assign axi_awsize_o  = axi_size(DATA_WIDTH);
    assign axi_awburst_o = AXI_BURST_INCR;
    // W channel is a combinational pass-through of the stream, gated to the W state
    assign axi_wvalid_o  = (state_q == W) && s_valid_i;
    assign axi_wdata_o   = s_data_i;
    assign axi_wstrb_o   = '1;
    assign axi_wlast_o   = (beat_q == axi_awlen_o);
    assign s_ready_o     = (state_q == W) && axi_wready_i && !rst_i;
    assign axi_bready_o  = (state_q == B);
    assign done_o        = (state_q == DONE);
    assign err_o         = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        id_d    = id_q;
        beat_d  = beat_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                addr_d  = cmd_addr_i;
                rem_d   = cmd_beats_i;
                id_d    = cmd_id_i;
                err_d   = 1'b0;
                state_d = (cmd_beats_i == '0) ? DONE : AW;
            end
            AW: if (axi_awready_i) begin
                beat_d  = '0;
                state_d = W;
            end
            W: if (axi_wvalid_o && axi_wready_i) begin
                beat_d  = beat_q + 8'd1;
                state_d = axi_wlast_o ? B : W;
            end
            B: if (axi_bvalid_i) begin
                err_d   = err_q | (axi_bresp_i != AXI_RESP_OKAY);
                rem_d   = rem_q - burst;
                addr_d  = addr_q + ADDR_WIDTH'(burst) * ADDR_WIDTH'(ADDR_STEP);
                state_d = (rem_q == burst) ? DONE : AW;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule
